// File: rtl/mem_wb_regfile.sv
// mem_wb_regfile: MEM/WB pipeline register plus 32-entry GPR file with two bypassed read ports
// Ports: clk/rst (sync, active-high); waddr_i/wreg_i/wdata_i write triple from memory stage;
// mem_stall_i/wb_stall_i/flush_i pipeline control; re*_i/raddr*_i/rdata*_o two combinational
// read ports; wb_waddr_o/wb_wreg_o/wb_wdata_o registered MEM/WB contents.
module mem_wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_stall_i,
  input  logic              wb_stall_i,
  input  logic              flush_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wb_waddr_o <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else if (!wb_stall_i) begin
      // a stalled memory stage becomes a bubble so its write is issued only once
      wb_waddr_o <= mem_stall_i ? '0 : waddr_i;
      wb_wreg_o  <= mem_stall_i ? 1'b0 : wreg_i;
      wb_wdata_o <= mem_stall_i ? '0 : wdata_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_wreg_o && wb_waddr_o != '0) begin
      regs[wb_waddr_o] <= wb_wdata_o;
    end
  end
  // the pending MEM/WB write is bypassed so decode sees it one cycle before commit
  always_comb begin
    rdata1_o = (rst || !re1_i || raddr1_i == '0) ? '0 :
               (wb_wreg_o && raddr1_i == wb_waddr_o) ? wb_wdata_o : regs[raddr1_i];
    rdata2_o = (rst || !re2_i || raddr2_i == '0) ? '0 :
               (wb_wreg_o && raddr2_i == wb_waddr_o) ? wb_wdata_o : regs[raddr2_i];
  end
endmodule

// File: tb/tb_mem_wb_regfile.sv
// tb_mem_wb_regfile: scoreboard bench for the MEM/WB register and GPR file
module tb_mem_wb_regfile;
  logic        clk = 1'b0;
  logic        rst, wreg, mem_stall, wb_stall, flush, re1, re2, wb_wreg;
  logic [4:0]  waddr, raddr1, raddr2, wb_waddr;
  logic [31:0] wdata, rdata1, rdata2, wb_wdata;
  logic [37:0] wb, exp_wb, cur;
  logic [37:0] q[$];
  int n_chk = 0;
  int n_fail = 0;
  assign wb = {wb_waddr, wb_wreg, wb_wdata};
  always #5 clk = ~clk;
  mem_wb_regfile dut (
    .clk(clk), .rst(rst), .waddr_i(waddr), .wreg_i(wreg), .wdata_i(wdata),
    .mem_stall_i(mem_stall), .wb_stall_i(wb_stall), .flush_i(flush),
    .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1),
    .re2_i(re2), .raddr2_i(raddr2), .rdata2_o(rdata2),
    .wb_waddr_o(wb_waddr), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata)
  );
  task automatic cyc(input logic r, input logic [4:0] a, input logic w, input logic [31:0] d,
                     input logic ms, input logic ws, input logic fl);
    rst = r; waddr = a; wreg = w; wdata = d; mem_stall = ms; wb_stall = ws; flush = fl;
    q.push_back((r || fl) ? 38'd0 : ws ? cur : ms ? 38'd0 : {a, w, d});
    @(posedge clk);
    #1;
    exp_wb = q.pop_front();
    cur = exp_wb;
  endtask
  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
  endtask
  task automatic test_reset();
    cyc(1'b1, 5'd3, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
    rd(1'b1, 5'd3, 1'b1, 5'd5);
    n_chk++; if (wb !== exp_wb) begin n_fail++; $display("FAIL reset_wb got %h exp %h", wb, exp_wb); end
    n_chk++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin n_fail++; $display("FAIL reset_rd got %h/%h exp 0", rdata1, rdata2); end
    idle();
  endtask
  task automatic test_basic();
    cyc(1'b0, 5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    rd(1'b1, 5'd3, 1'b0, 5'd0);
    n_chk++; if (wb !== exp_wb) begin n_fail++; $display("FAIL basic_wb got %h exp %h", wb, exp_wb); end
    n_chk++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_bypass got %h exp deadbeef", rdata1); end
    for (int i = 0; i < 2; i++) begin
      idle();
      n_chk++; if (wb !== exp_wb) begin n_fail++; $display("FAIL basic_idle_wb got %h exp %h", wb, exp_wb); end
      n_chk++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_store got %h exp deadbeef", rdata1); end
    end
  endtask
  task automatic test_zero();
    cyc(1'b0, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    rd(1'b1, 5'd0, 1'b1, 5'd0);
    n_chk++; if (wb !== exp_wb) begin n_fail++; $display("FAIL zero_wb got %h exp %h", wb, exp_wb); end
    n_chk++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin n_fail++; $display("FAIL zero_bypass got %h/%h exp 0", rdata1, rdata2); end
    idle();
    n_chk++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL zero_store got %h exp 0", rdata1); end
  endtask
  task automatic test_bypass();
    cyc(1'b0, 5'd5, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd5, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    rd(1'b1, 5'd5, 1'b1, 5'd5);
    n_chk++; if (wb !== exp_wb) begin n_fail++; $display("FAIL bypass_wb got %h exp %h", wb, exp_wb); end
    n_chk++; if (rdata1 !== 32'h22 || rdata2 !== 32'h22) begin n_fail++; $display("FAIL bypass_new got %h/%h exp 22", rdata1, rdata2); end
    idle();
    n_chk++; if (rdata1 !== 32'h22 || rdata2 !== 32'h22) begin n_fail++; $display("FAIL bypass_commit got %h/%h exp 22", rdata1, rdata2); end
  endtask
  task automatic test_stall_flush();
    cyc(1'b0, 5'd7, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'd8, 1'b1, 32'hBB, 1'b0, 1'b1, 1'b0);
      n_chk++; if (wb !== exp_wb || wb !== {5'd7, 1'b1, 32'hAA}) begin n_fail++; $display("FAIL stall_hold got %h exp %h", wb, exp_wb); end
    end
    idle();
    rd(1'b1, 5'd8, 1'b1, 5'd7);
    n_chk++; if (rdata1 !== 32'd0 || rdata2 !== 32'hAA) begin n_fail++; $display("FAIL stall_regs got %h/%h exp 0/aa", rdata1, rdata2); end
    cyc(1'b0, 5'd9, 1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
    n_chk++; if (wb_wreg !== 1'b0 || wb !== exp_wb) begin n_fail++; $display("FAIL mem_stall got %h exp %h", wb, exp_wb); end
    cyc(1'b0, 5'd10, 1'b1, 32'h1010, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd11, 1'b1, 32'h1111, 1'b0, 1'b1, 1'b1);
    rd(1'b1, 5'd10, 1'b1, 5'd11);
    n_chk++; if (wb !== 38'd0 || wb !== exp_wb) begin n_fail++; $display("FAIL flush_wins got %h exp %h", wb, exp_wb); end
    n_chk++; if (rdata1 !== 32'h1010 || rdata2 !== 32'd0) begin n_fail++; $display("FAIL flush_commit got %h/%h exp 1010/0", rdata1, rdata2); end
    idle();
  endtask
  task automatic test_reset_mid();
    for (int i = 1; i <= 4; i++) cyc(1'b0, 5'(i), 1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd9, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    rd(1'b1, 5'd2, 1'b1, 5'd9);
    n_chk++; if (rdata1 !== 32'd2 || rdata2 !== 32'h99) begin n_fail++; $display("FAIL mid_pre got %h/%h exp 2/99", rdata1, rdata2); end
    cyc(1'b1, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (wb !== exp_wb || rdata1 !== 32'd0 || rdata2 !== 32'd0) begin n_fail++; $display("FAIL mid_rst got %h %h/%h exp 0", wb, rdata1, rdata2); end
    idle();
    for (int i = 1; i <= 4; i++) begin
      rd(1'b1, 5'(i), 1'b1, 5'd9);
      n_chk++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin n_fail++; $display("FAIL mid_clear r%0d got %h r9 %h exp 0", i, rdata1, rdata2); end
    end
  endtask
  task automatic test_read_disable();
    cyc(1'b0, 5'd3, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    idle();
    rd(1'b0, 5'd3, 1'b0, 5'd3);
    n_chk++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin n_fail++; $display("FAIL re_off got %h/%h exp 0", rdata1, rdata2); end
    rd(1'b1, 5'd3, 1'b1, 5'd3);
    n_chk++; if (rdata1 !== 32'h55 || rdata2 !== 32'h55) begin n_fail++; $display("FAIL re_on got %h/%h exp 55", rdata1, rdata2); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] m [32];
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    for (int i = 0; i < 24; i++) begin
      logic [4:0] a;
      logic [31:0] d;
      a = 5'($urandom_range(1, 31));
      d = $urandom;
      cyc(1'b0, a, 1'b1, d, 1'b0, 1'b0, 1'b0);
      m[a] = d;
      rd(1'b1, a, 1'b1, 5'($urandom_range(1, 31)));
      n_chk++; if (wb !== exp_wb || rdata1 !== d || rdata2 !== m[raddr2]) begin n_fail++; $display("FAIL b2b got %h %h/%h exp %h %h/%h", wb, rdata1, rdata2, exp_wb, d, m[raddr2]); end
    end
  endtask
  initial begin
    cur = '0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_stall_flush();
    test_reset_mid();
    test_read_disable();
    test_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
